thiele_cpu: RTL and testbench



---
 rtl/thiele_cpu.sv | 256 +++++++++++++++++++++++++
 tb/tb_thiele_cpu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thiele_cpu.sv
// thiele_cpu: a small multi-cycle 32-bit Thiele-machine core.
// Each instruction is fetched in one cycle and executed in the next.
// ORACLE and PYEXEC requests go to external engines, and the core
// waits for their acknowledge before it moves on.
// It also keeps partition-module tables, MDL/info counters and a mu-cost total.
module thiele_cpu (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] cert_addr,
  output logic [31:0] status,
  output logic [31:0] error_code,
  output logic [31:0] partition_ops,
  output logic [31:0] mdl_ops,
  output logic [31:0] info_gain,
  output logic [31:0] mu,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_en,
  output logic        logic_req,
  output logic [31:0] logic_addr,
  input  logic        logic_ack,
  input  logic [31:0] logic_data,
  output logic        py_req,
  output logic [31:0] py_code_addr,
  input  logic        py_ack,
  input  logic [31:0] py_result,
  input  logic [31:0] instr_data,
  output logic [31:0] pc
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_EXEC       = 4'd1,
    S_WAIT_LOGIC = 4'd2,
    S_WAIT_PY    = 4'd3,
    S_HALTED     = 4'd4
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_PNEW   = 8'h01;
  localparam logic [7:0] OP_MDLACC = 8'h05;
  localparam logic [7:0] OP_XFER   = 8'h07;
  localparam logic [7:0] OP_LOAD   = 8'h0A;
  localparam logic [7:0] OP_ADD    = 8'h0B;
  localparam logic [7:0] OP_SWAP   = 8'h0C;
  localparam logic [7:0] OP_RANK   = 8'h0D;
  localparam logic [7:0] OP_REV    = 8'h0E;
  localparam logic [7:0] OP_PARITY = 8'h0F;
  localparam logic [7:0] OP_AND    = 8'h10;
  localparam logic [7:0] OP_STORE  = 8'h11;
  localparam logic [7:0] OP_ORACLE = 8'h13;
  localparam logic [7:0] OP_PYEXEC = 8'h14;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  state_t      state;
  state_t      w_state_next;

  logic [31:0] reg_file     [0:31];
  logic [31:0] data_mem     [0:255];
  logic [31:0] module_table [0:63];
  logic [31:0] region_table [0:63][0:7];

  logic [31:0] r_instr;
  logic [6:0]  r_next_id;

  logic [7:0]  w_op;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [31:0] w_cost;
  logic [4:0]  w_ra;
  logic [4:0]  w_rb;
  logic [31:0] w_rdata_a;
  logic [31:0] w_rdata_b;
  logic        w_legal;
  logic        w_table_full;
  logic        w_retire;
  logic        w_store;
  logic        w_unused;

  // mem_rdata belongs to the legacy port and nothing here reads it.
  assign w_unused = ^mem_rdata;

  assign w_op      = r_instr[31:24];
  assign w_a       = r_instr[23:16];
  assign w_b       = r_instr[15:8];
  assign w_cost    = {24'b0, r_instr[7:0]};
  assign w_ra      = w_a[4:0];
  assign w_rb      = w_b[4:0];
  assign w_rdata_a = reg_file[w_ra];
  assign w_rdata_b = reg_file[w_rb];

  assign w_table_full = (r_next_id == 7'd64);

  function automatic logic [31:0] popcount32(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Decode: is the opcode legal, and does it finish in EXEC with pc += 4?
  always_comb begin
    // NOTE: give every combinational output a default before any branch, so no path leaves it unassigned and no latch is inferred.
    w_legal  = 1'b0;
    w_retire = 1'b0;
    case (w_op)
      OP_NOP, OP_PNEW, OP_MDLACC, OP_XFER, OP_LOAD, OP_ADD, OP_SWAP,
      OP_RANK, OP_REV, OP_PARITY, OP_AND, OP_STORE: begin
        w_legal  = 1'b1;
        w_retire = !(w_op == OP_PNEW && w_table_full);
      end
      OP_ORACLE, OP_PYEXEC, OP_HALT: w_legal = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic for the fetch/execute/wait sequencer.
  always_comb begin
    w_state_next = state;
    case (state)
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC: begin
        if (!w_legal)                           w_state_next = S_HALTED;
        else if (w_op == OP_ORACLE)             w_state_next = S_WAIT_LOGIC;
        else if (w_op == OP_PYEXEC)             w_state_next = S_WAIT_PY;
        else if (w_op == OP_HALT)               w_state_next = S_HALTED;
        else if (w_op == OP_PNEW && w_table_full) w_state_next = S_HALTED;
        else                                    w_state_next = S_FETCH;
      end
      S_WAIT_LOGIC: if (logic_ack) w_state_next = S_FETCH;
      S_WAIT_PY:    if (py_ack)    w_state_next = S_FETCH;
      S_HALTED:     w_state_next = S_HALTED;
      default:      w_state_next = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state updates use non-blocking assignments, so every flop samples its inputs as they were before the edge.
    if (!rst_n) state <= S_FETCH;
    else        state <= w_state_next;
  end

  // The legacy write-through port is driven only while a STORE executes.
  assign w_store   = (state == S_EXEC) && (w_op == OP_STORE);
  assign mem_en    = w_store;
  assign mem_we    = w_store;
  assign mem_addr  = w_store ? {22'b0, w_b, 2'b00} : 32'd0;
  assign mem_wdata = w_store ? w_rdata_a : 32'd0;

  // status packs the halted and error flags together with the current state code.
  assign status = {24'b0, state, 2'b00, (error_code != 32'd0), (state == S_HALTED)};

  // Datapath: latch the instruction, apply op side effects, update counters and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= '0;
      r_instr       <= '0;
      r_next_id     <= 7'd1;
      cert_addr     <= '0;
      error_code    <= '0;
      partition_ops <= '0;
      mdl_ops       <= '0;
      info_gain     <= '0;
      mu            <= '0;
      logic_req     <= 1'b0;
      logic_addr    <= '0;
      py_req        <= 1'b0;
      py_code_addr  <= '0;
      // NOTE: these arrays are flop-based and have to be all zero after reset, so they are reset here explicitly rather than being left as uninitialised RAM.
      for (int i = 0; i < 32; i++)  reg_file[i] <= '0;
      for (int i = 0; i < 256; i++) data_mem[i] <= '0;
      for (int i = 0; i < 64; i++) begin
        module_table[i] <= '0;
        for (int j = 0; j < 8; j++) region_table[i][j] <= '0;
      end
    end else begin
      case (state)
        S_FETCH: r_instr <= instr_data;

        S_EXEC: begin
          if (w_retire) pc <= pc + 32'd4;
          if (w_retire || (w_op == OP_HALT)) mu <= mu + w_cost;
          if (!w_legal) error_code <= 32'd1;
          case (w_op)
            OP_PNEW: begin
              if (w_table_full) begin
                error_code <= 32'd2;
              end else begin
                region_table[r_next_id[5:0]][0] <= {24'b0, w_a};
                module_table[r_next_id[5:0]]    <= 32'd1;
                r_next_id     <= r_next_id + 7'd1;
                partition_ops <= partition_ops + 32'd1;
              end
            end
            OP_MDLACC: begin
              mdl_ops   <= mdl_ops + 32'd1;
              info_gain <= info_gain + module_table[w_a[5:0]];
            end
            OP_XFER:   reg_file[w_rb] <= w_rdata_a;
            OP_LOAD:   reg_file[w_ra] <= data_mem[w_b];
            OP_ADD:    reg_file[w_ra] <= w_rdata_a ^ w_rdata_b;
            OP_SWAP: begin
              reg_file[w_ra] <= w_rdata_b;
              reg_file[w_rb] <= w_rdata_a;
            end
            OP_RANK:   reg_file[w_ra] <= popcount32(w_rdata_b);
            OP_REV:    reg_file[w_ra] <= bitrev32(w_rdata_b);
            OP_PARITY: reg_file[w_ra] <= {31'b0, ^w_rdata_b};
            OP_AND:    reg_file[w_ra] <= w_rdata_a & w_rdata_b;
            OP_STORE:  data_mem[w_b]  <= w_rdata_a;
            OP_ORACLE: begin
              logic_addr <= w_rdata_a;
              cert_addr  <= w_rdata_a;
              logic_req  <= 1'b1;
            end
            OP_PYEXEC: begin
              py_code_addr <= {24'b0, w_b};
              py_req       <= 1'b1;
            end
            default: ;
          endcase
        end

        S_WAIT_LOGIC: begin
          if (logic_ack) begin
            reg_file[w_rb] <= logic_data;
            logic_req      <= 1'b0;
            pc             <= pc + 32'd4;
            mu             <= mu + w_cost;
          end
        end

        S_WAIT_PY: begin
          if (py_ack) begin
            reg_file[w_ra] <= py_result;
            py_req         <= 1'b0;
            pc             <= pc + 32'd4;
            mu             <= mu + w_cost;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thiele_cpu.sv
// Bench for thiele_cpu. It runs directed programs from a small instruction ROM.
// Expected memory writes and engine transactions go into queues, and monitor
// processes pop and compare them whenever the core presents a write or a request.
module tb_thiele_cpu;

  logic        clk;
  logic        rst_n;
  logic [31:0] cert_addr, status, error_code, partition_ops, mdl_ops;
  logic [31:0] info_gain, mu, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_en;
  logic        logic_req, logic_ack, py_req, py_ack;
  logic [31:0] logic_addr, logic_data, py_code_addr, py_result;
  logic [31:0] instr_data, pc;

  logic [31:0] prog [0:255];
  int          p;
  int          n_cmp;
  int          n_fail;
  int          n_oracle;
  logic        py_auto;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] result;
  } py_t;

  wr_t exp_wr [$];
  py_t py_q   [$];

  thiele_cpu dut (
    .clk(clk), .rst_n(rst_n), .cert_addr(cert_addr), .status(status),
    .error_code(error_code), .partition_ops(partition_ops), .mdl_ops(mdl_ops),
    .info_gain(info_gain), .mu(mu), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_en(mem_en),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack),
    .logic_data(logic_data), .py_req(py_req), .py_code_addr(py_code_addr),
    .py_ack(py_ack), .py_result(py_result), .instr_data(instr_data), .pc(pc)
  );

  assign instr_data = prog[pc[9:2]];
  assign mem_rdata  = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, wanted %08h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'hFF000000;
    p = 0;
  endtask

  task automatic emit(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] cost);
    prog[p] = {op, a, b, cost};
    p++;
  endtask

  task automatic exp_store(input logic [7:0] idx, input logic [31:0] data);
    exp_wr.push_back('{addr: {22'b0, idx, 2'b00}, data: data});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input string name, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (status[0]) break;
    end
    if (i == max_cycles) check({name, "_halt_timeout"}, 32'd0, 32'd1);
  endtask

  // Store monitor: every write pulse must match the next expected write.
  initial begin : store_monitor
    wr_t w;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        check("mem_we", {31'b0, mem_we}, 32'd1);
        if (exp_wr.size() == 0) begin
          check("unexpected_store", mem_addr, 32'hFFFFFFFF);
        end else begin
          w = exp_wr.pop_front();
          check("store_addr", mem_addr, w.addr);
          check("store_data", mem_wdata, w.data);
        end
      end
    end
  end

  // Oracle engine: acknowledges two cycles after it sees the request, then checks that req has dropped.
  initial begin : oracle_engine
    logic_ack  = 1'b0;
    logic_data = 32'd0;
    forever begin
      @(negedge clk);
      if (logic_req && rst_n) begin
        n_oracle++;
        check("logic_addr", logic_addr, 32'h00000038);
        check("cert_addr", cert_addr, 32'h00000038);
        repeat (2) @(negedge clk);
        check("logic_req_held", {31'b0, logic_req}, 32'd1);
        logic_ack  = 1'b1;
        logic_data = 32'hABCD1234;
        @(negedge clk);
        logic_ack  = 1'b0;
        logic_data = 32'd0;
        check("logic_req_drop", {31'b0, logic_req}, 32'd0);
      end
    end
  end

  // Python engine: serves queued results when enabled, and checks the code address and that req drops afterwards.
  initial begin : py_engine
    py_t item;
    py_ack    = 1'b0;
    py_result = 32'd0;
    forever begin
      @(negedge clk);
      if (py_req && py_auto && rst_n) begin
        if (py_q.size() == 0) begin
          check("unexpected_py_req", py_code_addr, 32'hFFFFFFFF);
        end else begin
          item = py_q.pop_front();
          check("py_code_addr", py_code_addr, item.code);
          @(negedge clk);
          py_ack    = 1'b1;
          py_result = item.result;
          @(negedge clk);
          py_ack    = 1'b0;
          py_result = 32'd0;
          check("py_req_drop", {31'b0, py_req}, 32'd0);
        end
      end
    end
  end

  initial begin : main
    int i;
    n_cmp    = 0;
    n_fail   = 0;
    n_oracle = 0;
    py_auto  = 1'b1;
    rst_n    = 1'b0;

    // Program 1: XOR algebra, stores, oracle and python engines.
    clear_prog();
    emit(8'h14, 8'h00, 8'h10, 8'h00);  py_q.push_back('{code: 32'h10, result: 32'h29});
    emit(8'h14, 8'h01, 8'h11, 8'h00);  py_q.push_back('{code: 32'h11, result: 32'h12});
    emit(8'h14, 8'h02, 8'h12, 8'h00);  py_q.push_back('{code: 32'h12, result: 32'h22});
    emit(8'h14, 8'h03, 8'h13, 8'h00);  py_q.push_back('{code: 32'h13, result: 32'h03});
    for (int k = 0; k < 4; k++) begin
      emit(8'h11, 8'(k), 8'(k), 8'h00);
    end
    exp_store(8'h00, 32'h29);
    exp_store(8'h01, 32'h12);
    exp_store(8'h02, 32'h22);
    exp_store(8'h03, 32'h03);
    for (int k = 0; k < 4; k++) emit(8'h0B, 8'(k), 8'(k), 8'h00);   // r[k] ^= r[k] -> 0
    emit(8'h11, 8'h00, 8'h08, 8'h00);  exp_store(8'h08, 32'h0);
    for (int k = 0; k < 4; k++) emit(8'h0A, 8'(k), 8'(k), 8'h00);   // reload r0..r3
    emit(8'h0B, 8'h03, 8'h00, 8'h00);  // r3 = 0x2A
    emit(8'h0B, 8'h03, 8'h01, 8'h00);  // r3 = 0x38
    emit(8'h0C, 8'h00, 8'h03, 8'h00);  // r0 = 0x38, r3 = 0x29
    emit(8'h0C, 8'h01, 8'h01, 8'h00);  // self swap: no-op
    emit(8'h07, 8'h02, 8'h04, 8'h00);  // r4 = 0x22
    emit(8'h0D, 8'h05, 8'h04, 8'h00);  // r5 = 2
    emit(8'h0E, 8'h06, 8'h04, 8'h00);  // r6 = 0x44000000
    emit(8'h0F, 8'h07, 8'h05, 8'h00);  // r7 = 1
    emit(8'h10, 8'h01, 8'h02, 8'h00);  // r1 = 0x02
    emit(8'h11, 8'h05, 8'h04, 8'h00);  exp_store(8'h04, 32'h2);
    emit(8'h11, 8'h06, 8'h05, 8'h00);  exp_store(8'h05, 32'h44000000);
    emit(8'h11, 8'h07, 8'h06, 8'h00);  exp_store(8'h06, 32'h1);
    emit(8'h11, 8'h00, 8'h07, 8'h00);  exp_store(8'h07, 32'h38);
    emit(8'h11, 8'h03, 8'h09, 8'h00);  exp_store(8'h09, 32'h29);
    emit(8'h11, 8'h04, 8'h0A, 8'h00);  exp_store(8'h0A, 32'h22);
    emit(8'h11, 8'h01, 8'h0B, 8'h00);  exp_store(8'h0B, 32'h02);
    emit(8'h13, 8'h00, 8'h08, 8'h00);  // r8 = oracle(r0)
    emit(8'h14, 8'h09, 8'h00, 8'h00);  py_q.push_back('{code: 32'h0, result: 32'h12345678});
    emit(8'h11, 8'h08, 8'h0C, 8'h00);  exp_store(8'h0C, 32'hABCD1234);
    emit(8'h11, 8'h09, 8'h0D, 8'h00);  exp_store(8'h0D, 32'h12345678);
    emit(8'hFF, 8'h00, 8'h00, 8'h00);  // HALT at pc 0x94

    @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_status", status, 32'd0);
    check("rst_mu", mu, 32'd0);
    check("rst_err", error_code, 32'd0);
    check("rst_reqs", {30'b0, logic_req, py_req}, 32'd0);
    do_reset();
    run_until_halt("prog1", 600);
    check("p1_pc", pc, 32'h94);
    check("p1_status", status, 32'h41);
    check("p1_err", error_code, 32'd0);
    check("p1_mu", mu, 32'd0);
    check("p1_r0", dut.reg_file[0], 32'h38);
    check("p1_r3", dut.reg_file[3], 32'h29);
    check("p1_r8", dut.reg_file[8], 32'hABCD1234);
    check("p1_r9", dut.reg_file[9], 32'h12345678);
    check("p1_mem4", dut.data_mem[4], 32'h2);
    check("p1_mem5", dut.data_mem[5], 32'h44000000);
    check("p1_mem6", dut.data_mem[6], 32'h1);
    check("p1_oracle_count", 32'(n_oracle), 32'd1);
    check("p1_stores_drained", 32'(exp_wr.size()), 32'd0);
    check("p1_py_drained", 32'(py_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("p1_pc_frozen", pc, 32'h94);

    // Program 2: partition modules, MDL accounting, cost accumulation.
    clear_prog();
    emit(8'h01, 8'h07, 8'h00, 8'h03);
    emit(8'h01, 8'h09, 8'h00, 8'h03);
    emit(8'h05, 8'h01, 8'h00, 8'h03);
    emit(8'hFF, 8'h00, 8'h00, 8'h03);
    do_reset();
    run_until_halt("prog2", 50);
    check("p2_partition_ops", partition_ops, 32'd2);
    check("p2_mdl_ops", mdl_ops, 32'd1);
    check("p2_info_gain", info_gain, 32'd1);
    check("p2_module1", dut.module_table[1], 32'd1);
    check("p2_region1", dut.region_table[1][0], 32'd7);
    check("p2_region2", dut.region_table[2][0], 32'd9);
    check("p2_mu", mu, 32'd12);
    check("p2_status", status, 32'h41);
    check("p2_pc", pc, 32'h0C);

    // Program 3: an illegal opcode stops the core without advancing pc.
    clear_prog();
    emit(8'h00, 8'h00, 8'h00, 8'h00);
    emit(8'h42, 8'h00, 8'h00, 8'h05);
    do_reset();
    run_until_halt("prog3", 50);
    check("p3_err", error_code, 32'd1);
    check("p3_status", status, 32'h43);
    check("p3_pc", pc, 32'h04);
    check("p3_mu", mu, 32'd0);

    // Program 4: the 64th PNEW finds the module table full.
    clear_prog();
    for (int k = 0; k < 64; k++) emit(8'h01, 8'(k), 8'h00, 8'h01);
    do_reset();
    run_until_halt("prog4", 400);
    check("p4_err", error_code, 32'd2);
    check("p4_status", status, 32'h43);
    check("p4_partition_ops", partition_ops, 32'd63);
    check("p4_pc", pc, 32'hFC);
    check("p4_mu", mu, 32'd63);
    check("p4_region63", dut.region_table[63][0], 32'd62);

    // Program 5: reset asserted during a PYEXEC wait.
    clear_prog();
    emit(8'h00, 8'h00, 8'h00, 8'h00);
    emit(8'h14, 8'h05, 8'h07, 8'h00);
    py_auto = 1'b0;
    do_reset();
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (py_req) break;
    end
    check("p5_py_req_seen", {31'b0, py_req}, 32'd1);
    check("p5_py_code", py_code_addr, 32'd7);
    check("p5_pc_wait", pc, 32'h04);
    check("p5_status_wait", status, 32'h30);
    repeat (3) @(negedge clk);
    check("p5_py_req_held", {31'b0, py_req}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("p5_py_req_reset", {31'b0, py_req}, 32'd0);
    check("p5_pc_reset", pc, 32'd0);
    check("p5_status_reset", status, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
